// File: rtl/imc_accum_ctrl_if.sv
// Bundle of the sequencer-side and datapath-side signals of imc_accum_ctrl.
// The controller uses the slave modport; whatever drives it (sequencer,
// adder-tree model, bench) uses the master modport.
//
// Handshakes:
//   start        : single-cycle request, looked at only while the controller
//                  is idle; in_bits / signed_mode are captured with it.
//   plane_req    : one-cycle pulse; plane_idx is meaningful only alongside it.
//   psum_valid   : psum is consumed on any cycle it is high while the
//                  controller waits for a plane, and ignored otherwise.
//   out_valid    : out_data is held stable while out_valid is high; the
//                  result transfers on the rising edge where
//                  out_valid && out_ready.
interface imc_accum_ctrl_if #(
  parameter int PSUM_W = 10,
  parameter int ACC_W  = 19
);
  logic              start;
  logic [3:0]        in_bits;
  logic              signed_mode;
  logic              busy;
  logic              plane_req;
  logic [2:0]        plane_idx;
  logic [PSUM_W-1:0] psum;
  logic              psum_valid;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              err;

  modport master (
    output start, in_bits, signed_mode, psum, psum_valid, out_ready,
    input  busy, plane_req, plane_idx, out_valid, out_data, err
  );

  modport slave (
    input  start, in_bits, signed_mode, psum, psum_valid, out_ready,
    output busy, plane_req, plane_idx, out_valid, out_data, err
  );
endinterface

// File: rtl/imc_accum_ctrl.sv
// Bit-serial accumulation controller for the IMC adder tree.
// Walks the bit-planes of one input vector MSB first: requests a plane,
// waits for the adder-tree partial sum and shift-accumulates it into a
// signed result. In two's-complement mode the MSB plane carries negative
// weight, so its partial sum is subtracted instead of added.
// plane_idx is 3 bits wide, so MAX_BITS must not exceed 8.
module imc_accum_ctrl #(
  parameter int PSUM_W   = 10,
  parameter int MAX_BITS = 8,
  parameter int ACC_W    = PSUM_W + MAX_BITS + 1,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  imc_accum_ctrl_if.slave   bus,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [3:0] MAX_BITS_4 = 4'(MAX_BITS);

  logic [1:0]       r_state;
  logic [2:0]       r_cnt;      // index of the plane currently in flight
  logic             r_signed;   // latched signed_mode
  logic             r_first;    // next accumulated plane is the MSB plane
  logic [TMO_W-1:0] r_tmo;      // wait cycles seen for the current plane
  logic [ACC_W-1:0] r_acc;
  logic             r_err;

  logic             w_start_ok;
  logic             w_take_psum;
  logic             w_tmo_hit;
  logic [ACC_W-1:0] w_psum_ext;
  logic [ACC_W-1:0] w_acc_shl;
  logic [ACC_W-1:0] w_acc_next;

  // A start is legal only with a precision of 1..MAX_BITS planes.
  assign w_start_ok = (bus.in_bits != 4'd0) && (bus.in_bits <= MAX_BITS_4);

  // psum is only meaningful while waiting on a requested plane.
  assign w_take_psum = (r_state == S_WAIT) && bus.psum_valid;

  // True on the TIMEOUT-th consecutive wait cycle without a partial sum.
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

  // Partial sums are unsigned; widen with zeros before the signed math.
  assign w_psum_ext = {{(ACC_W - PSUM_W){1'b0}}, bus.psum};
  assign w_acc_shl  = {r_acc[ACC_W-2:0], 1'b0};

  // MSB plane of a two's-complement input has weight -2^(N-1).
  assign w_acc_next = (r_signed && r_first) ? (w_acc_shl - w_psum_ext)
                                            : (w_acc_shl + w_psum_ext);

  // Control FSM: plane sequencing, timeout supervision and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_signed <= 1'b0;
      r_first  <= 1'b0;
      r_tmo    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_start_ok) begin
              r_signed <= bus.signed_mode;
              r_first  <= 1'b1;
              r_cnt    <= 3'(bus.in_bits - 4'd1);
              r_state  <= S_ISSUE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.psum_valid) begin
            r_first <= 1'b0;
            if (r_cnt == 3'd0) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt - 3'd1;
              r_state <= S_ISSUE;
            end
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Accumulator: cleared on an accepted start, updated once per plane,
  // dropped on a timeout so a stale partial result can never be presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if ((r_state == S_IDLE) && bus.start && w_start_ok) begin
      r_acc <= '0;
    end else if (w_take_psum) begin
      r_acc <= w_acc_next;
    end else if ((r_state == S_WAIT) && w_tmo_hit) begin
      r_acc <= '0;
    end
  end

  // Outputs decode straight from the state so they are 0 right after reset.
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.plane_req = (r_state == S_ISSUE);
  assign bus.plane_idx = (r_state == S_ISSUE) ? r_cnt : 3'd0;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = (r_state == S_DONE) ? r_acc : '0;
  assign bus.err       = r_err;

  assign o_dbg_state = r_state;

endmodule
